mips_debug_unit: RTL and testbench
==================================

Name: mips_debug_unit

Overview:
- Byte-stream debug controller for the 5-stage MIPS pipeline. It is the parametrised successor to the pipeline's fixed debug pins and its fixed set of 8 register-collector outputs.
- Sits between a UART byte pair (rx/tx valid/ready) and the MIPS top. It loads instruction memory, runs the pipeline in continuous or single-step mode, and serialises a snapshot back to the host.
- The snapshot contains PC, cycle count, NUM_REGS registers and one memory word.

Parameters:
- LEN_DATA, 32, datapath and word width; must be a multiple of 8.
- LEN_ADDR, 8, instruction-memory address width.
- NUM_REGS, 8, number of collected registers in the snapshot.
- BPW, LEN_DATA/8, bytes per word (derived; not overridable).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  unit accepts a byte this cycle
- tx_data  out  8  byte to host
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host side accepts the byte
- debug_flag  out  1  high while instruction memory is being loaded
- out_addr_mem_inst  out  LEN_ADDR  instruction-memory write address
- out_ins_to_mem  out  LEN_DATA  instruction-memory write data
- wea_ram_inst  out  1  one-cycle write strobe
- mips_en  out  1  pipeline clock enable
- mips_reset  out  1  one-cycle pipeline restart pulse
- halt_flag  in  1  pipeline halt, from MEM/WB
- in_pc  in  LEN_DATA  current PC
- in_regs  in  NUM_REGS*LEN_DATA  flattened registers; reg i occupies [i*LEN_DATA +: LEN_DATA]
- in_mem_word  in  LEN_DATA  debug memory word
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0 except rx_ready=1. State=IDLE; address, byte index, cycle counter and step flag all 0.
- Byte handshake:
  - A byte transfers when rx_valid & rx_ready.
  - rx_ready=1 only in IDLE, LOAD_CNT, LOAD_BYTE and STEP_WAIT.
  - tx_valid, once asserted, holds tx_data stable until tx_ready.
- Commands in IDLE; unknown bytes are discarded and the state stays IDLE:
  - 8'h4C 'L' -> LOAD_CNT.
  - 8'h43 'C' -> RUN.
  - 8'h53 'S' -> STEP_WAIT.
  - Entering RUN or STEP_WAIT pulses mips_reset for 1 cycle and clears the cycle counter.
- LOAD_CNT:
  - The next byte is the word count N. N=0 returns to IDLE with no writes.
  - Otherwise address=0, go to LOAD_BYTE; debug_flag=1 from LOAD_CNT through LOAD_WRITE.
- LOAD_BYTE:
  - Bytes are assembled MSB first into out_ins_to_mem.
  - After byte BPW-1, go to LOAD_WRITE.
- LOAD_WRITE:
  - wea_ram_inst=1 for exactly 1 cycle with the current address and data.
  - Then address+1, wrapping modulo 2^LEN_ADDR; the word count is decremented.
  - Count reaches 0 -> IDLE with debug_flag=0; otherwise back to LOAD_BYTE.
- RUN:
  - mips_en=1 every cycle; cycle counter +1 per enabled cycle (wraps at 2^LEN_DATA).
  - When halt_flag=1 is sampled, mips_en drops the same cycle and the state goes to SNAP.
- STEP_WAIT (mips_en=0):
  - 8'h4E 'N' -> STEP_EXEC.
  - 8'h45 'E' -> IDLE.
  - Other bytes are ignored.
- STEP_EXEC:
  - mips_en=1 for exactly 1 cycle; counter +1; then SNAP with the step flag set.
- SNAP:
  - One cycle. Registers in_pc, counter, in_regs and in_mem_word into a snapshot buffer of NUM_REGS+3 words; word index=0.
  - Later input changes do not affect the dump.
- DUMP, word order: PC, cycle count, reg0..reg(NUM_REGS-1), mem word.
  - Each word is sent as BPW bytes, MSB first.
  - After the last byte is accepted:
    - Step flag set and halt_flag=0 -> STEP_WAIT.
    - Otherwise -> IDLE, and the step flag clears.
- A halt during a step dumps, then returns to IDLE.
- A halt during the mips_reset cycle is ignored; halt_flag is sampled only while mips_en=1.
- A reset in any state aborts the operation the same cycle: no further wea pulses; tx_valid drops; the partial word is discarded.
- Simultaneous tx_ready and the last byte is a normal completion; no extra byte is sent.

Decomposition:
- Package mips_dbg_pkg holds:
  - the state enum;
  - command constants CMD_LOAD, CMD_CONT, CMD_STEP, CMD_NEXT, CMD_EXIT;
  - the DUMP_WORDS=NUM_REGS+3 helper function.
- One sub-module: dbg_word_serializer. It loads a LEN_DATA word and emits BPW bytes over valid/ready, MSB first, raising done on the final accepted byte. It is instantiated once by DUMP.

Test Plan:
- Load:
  - Stimulus: 4C, 02, 20 01 00 05, 20 02 00 07.
  - Required: wea pulses at addr 0 with data 0x20010005, then at addr 1 with 0x20020007.
  - debug_flag is high throughout and 0 afterwards; N=0 produces no wea.
- Continuous run:
  - Stimulus: 43, with halt_flag asserted after 10 enabled cycles.
  - Required: one mips_reset pulse; mips_en high for 10 cycles; 44 bytes out (DUMP_WORDS=11, 4 bytes each) with the count word 0x0000000A.
- Step mode:
  - Stimulus: 53, 4E, 4E.
  - Required: each 4E yields exactly one mips_en cycle and one 44-byte dump, with count words 1 then 2.
  - A subsequent 45 returns to IDLE with busy=0.
- Backpressure:
  - Stimulus: tx_ready toggling 1-0-0-1.
  - Required: tx_data is held stable while stalled; byte order PC[31:24] first; no duplicated or lost bytes.
- Snapshot stability: in_regs changed during DUMP -> dumped values equal those captured at SNAP.
- Reset mid-load:
  - Stimulus: reset after 2 bytes of word 0.
  - Required: no wea; outputs return to reset values; a fresh 4C load works from addr 0.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared types, command bytes and helpers for the MIPS byte-stream debug unit.
package mips_dbg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_LOAD_WRITE,
        ST_RUN,
        ST_STEP_WAIT,
        ST_STEP_EXEC,
        ST_SNAP,
        ST_DUMP
    } dbg_state_e;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_EXIT = 8'h45;

    // Snapshot length in words: PC, cycle count, registers, memory word.
    function automatic int unsigned dump_words(input int unsigned num_regs);
        return num_regs + 3;
    endfunction

    // States in which the unit is willing to take a host byte.
    function automatic logic accepts_rx(input dbg_state_e s);
        return (s == ST_IDLE) || (s == ST_LOAD_CNT) ||
               (s == ST_LOAD_BYTE) || (s == ST_STEP_WAIT);
    endfunction

    // States belonging to an instruction-memory load.
    function automatic logic in_load(input dbg_state_e s);
        return (s == ST_LOAD_CNT) || (s == ST_LOAD_BYTE) || (s == ST_LOAD_WRITE);
    endfunction

endpackage

// File: rtl/mips_debug_unit_serializer.sv
// Emits one LEN_DATA word as BPW bytes over valid/ready, most significant byte first.
module dbg_word_serializer
    import mips_dbg_pkg::*;
#(
    parameter int unsigned LEN_DATA = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [LEN_DATA-1:0] word_i,
    input  logic                tx_ready_i,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    output logic                done_c_o
);

    localparam int unsigned BPW   = LEN_DATA / 8;
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [LEN_DATA-1:0] sh_q;
    logic [IDX_W-1:0]    idx_q;
    logic                valid_q;
    logic                last_c;

    assign last_c     = (idx_q == IDX_W'(BPW - 1));
    assign done_c_o   = valid_q & tx_ready_i & last_c;
    assign tx_data_o  = sh_q[LEN_DATA-1 -: 8];
    assign tx_valid_o = valid_q;

    // Shift register: load a word, advance one byte per accepted transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            sh_q    <= word_i;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && tx_ready_i) begin
            if (last_c) begin
                valid_q <= 1'b0;
            end else begin
                sh_q  <= sh_q << 8;
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/mips_debug_unit.sv
// Byte-stream debug controller: loads instruction memory, runs/steps the pipeline, dumps a snapshot.
module mips_debug_unit
    import mips_dbg_pkg::*;
#(
    parameter int unsigned LEN_DATA = 32,
    parameter int unsigned LEN_ADDR = 8,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         debug_flag,
    output logic [LEN_ADDR-1:0]          out_addr_mem_inst,
    output logic [LEN_DATA-1:0]          out_ins_to_mem,
    output logic                         wea_ram_inst,
    output logic                         mips_en,
    output logic                         mips_reset,
    input  logic                         halt_flag,
    input  logic [LEN_DATA-1:0]          in_pc,
    input  logic [NUM_REGS*LEN_DATA-1:0] in_regs,
    input  logic [LEN_DATA-1:0]          in_mem_word,
    output logic                         busy
);

    localparam int unsigned BPW        = LEN_DATA / 8;
    localparam int unsigned IDX_W      = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned DUMP_WORDS = dump_words(NUM_REGS);
    localparam int unsigned WIDX_W     = $clog2(DUMP_WORDS);
    localparam int unsigned SNAP_W     = DUMP_WORDS * LEN_DATA;

    dbg_state_e          state_q, state_d;
    logic [LEN_ADDR-1:0] addr_q, addr_d;
    logic [LEN_DATA-1:0] word_q, word_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]          wcnt_q, wcnt_d;
    logic [LEN_DATA-1:0] cycle_q, cycle_d;
    logic                step_q, step_d;
    logic                wea_q, wea_d;
    logic                en_q, en_d;
    logic                mrst_q, mrst_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic                ser_load_q, ser_load_d;
    logic                rx_ready_q, debug_q, busy_q;
    logic [SNAP_W-1:0]   snap_q;

    logic                rx_fire_c;
    logic                ser_done_c;
    logic [LEN_DATA-1:0] ser_word_c;

    assign rx_fire_c  = rx_valid & rx_ready_q;
    assign ser_word_c = LEN_DATA'(snap_q >> (LEN_DATA * 32'(widx_q)));

    assign rx_ready          = rx_ready_q;
    assign debug_flag        = debug_q;
    assign busy              = busy_q;
    assign out_addr_mem_inst = addr_q;
    assign out_ins_to_mem    = word_q;
    assign wea_ram_inst      = wea_q;
    assign mips_reset        = mrst_q;
    // A sampled halt must stop the pipeline in the same cycle, so the enable is gated here.
    assign mips_en           = en_q & ~((state_q == ST_RUN) & halt_flag);

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        wcnt_d     = wcnt_q;
        cycle_d    = cycle_q;
        step_d     = step_q;
        wea_d      = 1'b0;
        en_d       = en_q;
        mrst_d     = 1'b0;
        widx_d     = widx_q;
        ser_load_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                step_d = 1'b0;
                if (rx_fire_c) begin
                    if (rx_data == CMD_LOAD) begin
                        state_d = ST_LOAD_CNT;
                    end else if (rx_data == CMD_CONT) begin
                        state_d = ST_RUN;
                        mrst_d  = 1'b1;
                        cycle_d = '0;
                    end else if (rx_data == CMD_STEP) begin
                        state_d = ST_STEP_WAIT;
                        mrst_d  = 1'b1;
                        cycle_d = '0;
                    end
                end
            end
            ST_LOAD_CNT: begin
                if (rx_fire_c) begin
                    if (rx_data == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        wcnt_d     = rx_data;
                        addr_d     = '0;
                        byte_idx_d = '0;
                        state_d    = ST_LOAD_BYTE;
                    end
                end
            end
            ST_LOAD_BYTE: begin
                if (rx_fire_c) begin
                    word_d = (word_q << 8) | LEN_DATA'(rx_data);
                    if (byte_idx_q == IDX_W'(BPW - 1)) begin
                        byte_idx_d = '0;
                        wea_d      = 1'b1;
                        state_d    = ST_LOAD_WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_LOAD_WRITE: begin
                addr_d = addr_q + LEN_ADDR'(1);
                wcnt_d = wcnt_q - 8'd1;
                state_d = (wcnt_q == 8'd1) ? ST_IDLE : ST_LOAD_BYTE;
            end
            ST_RUN: begin
                // First RUN cycle is the pipeline restart; halt is only looked at once enabled.
                if (mrst_q) begin
                    en_d = 1'b1;
                end else if (en_q) begin
                    if (halt_flag) begin
                        en_d    = 1'b0;
                        state_d = ST_SNAP;
                    end else begin
                        cycle_d = cycle_q + LEN_DATA'(1);
                    end
                end
            end
            ST_STEP_WAIT: begin
                if (rx_fire_c) begin
                    if (rx_data == CMD_NEXT) begin
                        en_d    = 1'b1;
                        state_d = ST_STEP_EXEC;
                    end else if (rx_data == CMD_EXIT) begin
                        step_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STEP_EXEC: begin
                en_d    = 1'b0;
                cycle_d = cycle_q + LEN_DATA'(1);
                step_d  = 1'b1;
                state_d = ST_SNAP;
            end
            ST_SNAP: begin
                widx_d     = '0;
                ser_load_d = 1'b1;
                state_d    = ST_DUMP;
            end
            ST_DUMP: begin
                if (ser_done_c) begin
                    if (widx_q == WIDX_W'(DUMP_WORDS - 1)) begin
                        if (step_q && !halt_flag) begin
                            state_d = ST_STEP_WAIT;
                        end else begin
                            step_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        widx_d     = widx_q + WIDX_W'(1);
                        ser_load_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            wcnt_q     <= '0;
            cycle_q    <= '0;
            step_q     <= 1'b0;
            wea_q      <= 1'b0;
            en_q       <= 1'b0;
            mrst_q     <= 1'b0;
            widx_q     <= '0;
            ser_load_q <= 1'b0;
            rx_ready_q <= 1'b1;
            debug_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            wcnt_q     <= wcnt_d;
            cycle_q    <= cycle_d;
            step_q     <= step_d;
            wea_q      <= wea_d;
            en_q       <= en_d;
            mrst_q     <= mrst_d;
            widx_q     <= widx_d;
            ser_load_q <= ser_load_d;
            rx_ready_q <= accepts_rx(state_d);
            debug_q    <= in_load(state_d);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    // Snapshot buffer, word 0 in the low bits: PC, count, reg0..regN-1, memory word.
    always_ff @(posedge clk) begin
        if (state_q == ST_SNAP) begin
            snap_q <= {in_mem_word, in_regs, cycle_q, in_pc};
        end
    end

    dbg_word_serializer #(
        .LEN_DATA (LEN_DATA)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ser_load_q),
        .word_i     (ser_word_c),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .done_c_o   (ser_done_c)
    );

endmodule

// File: tb/tb_mips_debug_unit.sv
// Directed bench for mips_debug_unit: load, run, step, backpressure, snapshot and reset cases.
module tb_mips_debug_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         debug_flag;
    logic [7:0]   out_addr_mem_inst;
    logic [31:0]  out_ins_to_mem;
    logic         wea_ram_inst;
    logic         mips_en;
    logic         mips_reset;
    logic         halt_flag;
    logic [31:0]  in_pc;
    logic [255:0] in_regs;
    logic [31:0]  in_mem_word;
    logic         busy;

    int checks = 0;
    int errors = 0;

    int          wea_cnt = 0;
    logic [7:0]  wea_addr [8];
    logic [31:0] wea_data [8];
    logic        wea_dbg  [8];
    int          rstp_cnt = 0;
    int          en_cnt   = 0;

    logic [7:0]  dump_b [44];
    logic [31:0] dump_w [11];

    mips_debug_unit dut (
        .clk               (clk),
        .reset             (reset),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .debug_flag        (debug_flag),
        .out_addr_mem_inst (out_addr_mem_inst),
        .out_ins_to_mem    (out_ins_to_mem),
        .wea_ram_inst      (wea_ram_inst),
        .mips_en           (mips_en),
        .mips_reset        (mips_reset),
        .halt_flag         (halt_flag),
        .in_pc             (in_pc),
        .in_regs           (in_regs),
        .in_mem_word       (in_mem_word),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Passive monitor of write strobes, restart pulses and enabled cycles.
    always @(negedge clk) begin
        if (wea_ram_inst && wea_cnt < 8) begin
            wea_addr[wea_cnt] <= out_addr_mem_inst;
            wea_data[wea_cnt] <= out_ins_to_mem;
            wea_dbg[wea_cnt]  <= debug_flag;
        end
        if (wea_ram_inst) wea_cnt <= wea_cnt + 1;
        if (mips_reset)   rstp_cnt <= rstp_cnt + 1;
        if (mips_en)      en_cnt <= en_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("rx_timeout", 64'(t), 64'(0));
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic set_inputs(input logic [31:0] pc, input logic [31:0] rbase, input logic [31:0] mem);
        in_pc       = pc;
        in_mem_word = mem;
        for (int i = 0; i < 8; i++) in_regs[i*32 +: 32] = rbase + 32'(i);
    endtask

    // Collect 44 bytes; with bp set, tx_ready follows 1,0,0,1 and stalled bytes must hold.
    task automatic recv_dump(input bit bp);
        int nb = 0;
        int t = 0;
        bit stalled = 1'b0;
        logic [7:0] held = 8'h00;
        while (nb < 44 && t < 3000) begin
            tx_ready = bp ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (stalled) begin
                check("hold_valid", 64'(tx_valid), 64'(1));
                check("hold_data", 64'(tx_data), 64'(held));
            end
            if (tx_valid && tx_ready) begin
                dump_b[nb] = tx_data;
                nb++;
                stalled = 1'b0;
            end else if (tx_valid) begin
                stalled = 1'b1;
                held = tx_data;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk);
            #1;
            t++;
        end
        tx_ready = 1'b1;
        check("dump_bytes", 64'(nb), 64'(44));
        for (int w = 0; w < 11; w++)
            dump_w[w] = {dump_b[4*w], dump_b[4*w+1], dump_b[4*w+2], dump_b[4*w+3]};
        tick(2);
        check("no_extra_byte", 64'(tx_valid), 64'(0));
    endtask

    task automatic check_dump(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                              input logic [31:0] rbase, input logic [31:0] mem);
        check({tag, "_pc"}, 64'(dump_w[0]), 64'(pc));
        check({tag, "_count"}, 64'(dump_w[1]), 64'(cnt));
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_reg%0d", tag, i), 64'(dump_w[2+i]), 64'(rbase + 32'(i)));
        check({tag, "_mem"}, 64'(dump_w[10]), 64'(mem));
    endtask

    initial begin
        int n;
        int t;
        int base_rst;
        int base_en;
        int base_wea;
        logic [7:0] b0;

        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; halt_flag = 1'b0;
        set_inputs(32'h0000_0040, 32'hA000_0000, 32'hDEAD_BEEF);
        tick(3);
        check("rst_rx_ready", 64'(rx_ready), 64'(1));
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_debug", 64'(debug_flag), 64'(0));
        check("rst_wea", 64'(wea_ram_inst), 64'(0));
        check("rst_en", 64'(mips_en), 64'(0));
        check("rst_mreset", 64'(mips_reset), 64'(0));
        check("rst_addr", 64'(out_addr_mem_inst), 64'(0));
        check("rst_ins", 64'(out_ins_to_mem), 64'(0));
        reset = 1'b0;
        tick(1);

        // Two-word load.
        send_byte(8'h4C);
        check("load_debug_on", 64'(debug_flag), 64'(1));
        check("load_busy", 64'(busy), 64'(1));
        send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h07);
        tick(2);
        check("load_wea_cnt", 64'(wea_cnt), 64'(2));
        check("load_addr0", 64'(wea_addr[0]), 64'(0));
        check("load_data0", 64'(wea_data[0]), 64'(32'h2001_0005));
        check("load_dbg0", 64'(wea_dbg[0]), 64'(1));
        check("load_addr1", 64'(wea_addr[1]), 64'(1));
        check("load_data1", 64'(wea_data[1]), 64'(32'h2002_0007));
        check("load_dbg1", 64'(wea_dbg[1]), 64'(1));
        check("load_debug_off", 64'(debug_flag), 64'(0));
        check("load_idle", 64'(busy), 64'(0));

        // Zero-length load writes nothing.
        send_byte(8'h4C);
        send_byte(8'h00);
        tick(3);
        check("n0_wea_cnt", 64'(wea_cnt), 64'(2));
        check("n0_debug", 64'(debug_flag), 64'(0));
        check("n0_idle", 64'(busy), 64'(0));

        // Unknown command is dropped.
        send_byte(8'h7A);
        tick(1);
        check("unknown_idle", 64'(busy), 64'(0));

        // Continuous run halted after 10 enabled cycles.
        base_rst = rstp_cnt;
        base_en  = en_cnt;
        send_byte(8'h43);
        n = 0; t = 0;
        while (n < 10 && t < 200) begin
            @(negedge clk);
            if (mips_en) n++;
            t++;
        end
        check("run_en_seen", 64'(n), 64'(10));
        @(posedge clk);
        #1;
        halt_flag = 1'b1;
        recv_dump(1'b0);
        halt_flag = 1'b0;
        check_dump("run", 32'h0000_0040, 32'd10, 32'hA000_0000, 32'hDEAD_BEEF);
        check("run_rst_pulses", 64'(rstp_cnt - base_rst), 64'(1));
        check("run_en_cycles", 64'(en_cnt - base_en), 64'(10));
        check("run_idle", 64'(busy), 64'(0));

        // Step mode with backpressure and inputs changed during the dump.
        base_rst = rstp_cnt;
        send_byte(8'h53);
        tick(2);
        check("step_rst_pulses", 64'(rstp_cnt - base_rst), 64'(1));
        check("step_wait_en", 64'(mips_en), 64'(0));
        check("step_wait_ready", 64'(rx_ready), 64'(1));
        base_en = en_cnt;
        tx_ready = 1'b0;
        send_byte(8'h4E);
        tick(3);
        set_inputs(32'h0000_0044, 32'hB000_0000, 32'hCAFE_F00D);
        recv_dump(1'b1);
        b0 = dump_b[0];
        check("bp_first_byte", 64'(b0), 64'(8'h00));
        check("bp_pc_low_byte", 64'(dump_b[3]), 64'(8'h40));
        check_dump("step1", 32'h0000_0040, 32'd1, 32'hA000_0000, 32'hDEAD_BEEF);
        check("step1_en_cycles", 64'(en_cnt - base_en), 64'(1));
        check("step1_back_wait", 64'(busy), 64'(1));
        check("step1_ready", 64'(rx_ready), 64'(1));
        base_en = en_cnt;
        send_byte(8'h4E);
        recv_dump(1'b0);
        check_dump("step2", 32'h0000_0044, 32'd2, 32'hB000_0000, 32'hCAFE_F00D);
        check("step2_en_cycles", 64'(en_cnt - base_en), 64'(1));
        send_byte(8'h45);
        tick(1);
        check("step_exit_idle", 64'(busy), 64'(0));

        // Halt during a step dumps and then goes idle.
        send_byte(8'h53);
        halt_flag = 1'b1;
        send_byte(8'h4E);
        recv_dump(1'b0);
        check_dump("step_halt", 32'h0000_0044, 32'd1, 32'hB000_0000, 32'hCAFE_F00D);
        tick(1);
        check("step_halt_idle", 64'(busy), 64'(0));

        // Halt held through the restart cycle: stops before any enabled cycle.
        base_en = en_cnt;
        send_byte(8'h43);
        recv_dump(1'b0);
        halt_flag = 1'b0;
        check("halt_rst_count", 64'(dump_w[1]), 64'(0));
        check("halt_rst_en", 64'(en_cnt - base_en), 64'(0));
        check("halt_rst_idle", 64'(busy), 64'(0));

        // Reset in the middle of a load, then a fresh load.
        base_wea = wea_cnt;
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        tick(1);
        check("mid_rst_wea", 64'(wea_ram_inst), 64'(0));
        check("mid_rst_ready", 64'(rx_ready), 64'(1));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_debug", 64'(debug_flag), 64'(0));
        check("mid_rst_ins", 64'(out_ins_to_mem), 64'(0));
        check("mid_rst_addr", 64'(out_addr_mem_inst), 64'(0));
        reset = 1'b0;
        tick(2);
        check("mid_rst_no_wea", 64'(wea_cnt - base_wea), 64'(0));
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        tick(2);
        check("reload_wea_cnt", 64'(wea_cnt - base_wea), 64'(1));
        check("reload_addr", 64'(wea_addr[base_wea]), 64'(0));
        check("reload_data", 64'(wea_data[base_wea]), 64'(32'h1122_3344));
        check("reload_idle", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
